// File: rtl/datapath_pkg.sv
// Shared definitions for param_datapath: ALU opcodes, flag bit positions,
// BCD converter state encoding and the display digit-count check.
package datapath_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_PASS = 4'd8,
        ALU_INC  = 4'd9,
        ALU_DEC  = 4'd10
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic {
        BCD_IDLE  = 1'b0,
        BCD_SHIFT = 1'b1
    } bcd_state_e;

    // True when 'digits' decimal digits can show every unsigned data_w-bit value.
    function automatic bit bcd_digits_ok(input int data_w, input int digits);
        longint unsigned p10;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        return p10 > ((longint'(1) << data_w) - 1);
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle,
// result published after DATA_W shifts; a new start aborts any conversion.
module bcd_converter
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    valid,
    output logic [4*BCD_DIGITS-1:0] digits
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    bcd_state_e        state_q;
    logic [DATA_W-1:0] sr_q;
    logic [BCD_W-1:0]  acc_q;
    logic [BCD_W-1:0]  acc_adj;
    logic [BCD_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCD_W-1:0]  digits_q;
    logic              busy_q;
    logic              valid_q;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d = {acc_adj[BCD_W-2:0], sr_q[DATA_W-1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= BCD_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
        end else if (start) begin
            state_q <= BCD_SHIFT;
            sr_q    <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BCD_SHIFT: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    // The final shift's accumulator goes straight to the display.
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        digits_q <= acc_d;
                        state_q  <= BCD_IDLE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BCD_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign digits = digits_q;

endmodule

// File: rtl/param_datapath.sv
// Parametrised datapath: register file, inline ALU with flags, PC, MAR, IR and
// BCD display path. Define DATAPATH_BCD_EN to build the BCD converter.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 4,
    parameter int ADDR_W     = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(REG_COUNT)-1:0] reg_sel,
    input  logic                         reg_write,
    input  logic                         reg_read,
    input  logic [3:0]                   alu_op,
    input  logic                         alu_latch,
    input  logic                         alu_grab,
    input  logic [DATA_W-1:0]            data_bus_in,
    output logic [DATA_W-1:0]            data_bus_out,
    input  logic                         pc_inc,
    input  logic                         pc_load,
    output logic [ADDR_W-1:0]            pc_count,
    input  logic                         mar_write,
    input  logic                         ir_write,
    output logic [ADDR_W-1:0]            mar_value,
    output logic [DATA_W-1:0]            ir_value,
    output logic [3:0]                   flags,
    output logic                         bcd_busy,
    output logic                         bcd_valid,
    output logic [4*BCD_DIGITS-1:0]      bcd_digits
);

    localparam int MSB = DATA_W - 1;

    if (!bcd_digits_ok(DATA_W, BCD_DIGITS)) begin : g_bad_digits
        $error("BCD_DIGITS too small to display every DATA_W-bit value");
    end
    if (ADDR_W > DATA_W) begin : g_bad_addr
        $error("ADDR_W must not exceed DATA_W");
    end

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] result_q;
    logic [3:0]        flags_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        flags_d;

    assign op_a = regs_q[reg_sel];
    assign op_b = data_bus_in;

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                wide    = {1'b0, op_a} + {1'b0, op_b};
                alu_res = wide[MSB:0];
                alu_c   = wide[DATA_W];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                // The extra top bit of the widened difference is the borrow (A < B).
                wide    = {1'b0, op_a} - {1'b0, op_b};
                alu_res = wide[MSB:0];
                alu_c   = wide[DATA_W];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOT:  alu_res = ~op_a;
            ALU_SHL: begin
                alu_res = op_a << 1;
                alu_c   = op_a[MSB];
            end
            ALU_SHR: begin
                alu_res = op_a >> 1;
                alu_c   = op_a[0];
            end
            ALU_PASS: alu_res = op_b;
            ALU_INC: begin
                wide    = {1'b0, op_a} + (DATA_W+1)'(1);
                alu_res = wide[MSB:0];
                alu_c   = wide[DATA_W];
                alu_v   = !op_a[MSB] && alu_res[MSB];
            end
            ALU_DEC: begin
                wide    = {1'b0, op_a} - (DATA_W+1)'(1);
                alu_res = wide[MSB:0];
                alu_c   = wide[DATA_W];
                alu_v   = op_a[MSB] && !alu_res[MSB];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_N] = alu_res[MSB];
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = data_bus_in[ADDR_W-1:0];
        end else if (pc_inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            result_q <= '0;
            flags_q  <= '0;
            pc_q     <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
        end else begin
            if (reg_write) regs_q[reg_sel] <= data_bus_in;
            if (alu_latch) begin
                result_q <= alu_res;
                flags_q  <= flags_d;
            end
            pc_q <= pc_d;
            if (mar_write) mar_q <= data_bus_in[ADDR_W-1:0];
            if (ir_write)  ir_q  <= data_bus_in;
        end
    end

    always_comb begin
        data_bus_out = '0;
        if (alu_grab) begin
            data_bus_out = result_q;
        end else if (reg_read) begin
            data_bus_out = regs_q[reg_sel];
        end
    end

    assign pc_count  = pc_q;
    assign mar_value = mar_q;
    assign ir_value  = ir_q;
    assign flags     = flags_q;

`ifdef DATAPATH_BCD_EN
    bcd_converter #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .start  (alu_latch),
        .value  (alu_res),
        .busy   (bcd_busy),
        .valid  (bcd_valid),
        .digits (bcd_digits)
    );
`else
    assign bcd_busy   = 1'b0;
    assign bcd_valid  = 1'b0;
    assign bcd_digits = '0;
`endif

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: directed scenarios plus random
// traffic against a decimal/integer reference model; also a 12-bit build.
module tb_param_datapath;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Default build (8-bit, 4 registers, 3 digits)
    logic        reset;
    logic [1:0]  reg_sel;
    logic        reg_write, reg_read, alu_latch, alu_grab;
    logic [3:0]  alu_op;
    logic [7:0]  data_bus_in, data_bus_out;
    logic        pc_inc, pc_load, mar_write, ir_write;
    logic [7:0]  pc_count, mar_value, ir_value;
    logic [3:0]  flags;
    logic        bcd_busy, bcd_valid;
    logic [11:0] bcd_digits;

    param_datapath dut (
        .clock(clock), .reset(reset), .reg_sel(reg_sel), .reg_write(reg_write),
        .reg_read(reg_read), .alu_op(alu_op), .alu_latch(alu_latch), .alu_grab(alu_grab),
        .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .pc_inc(pc_inc),
        .pc_load(pc_load), .pc_count(pc_count), .mar_write(mar_write), .ir_write(ir_write),
        .mar_value(mar_value), .ir_value(ir_value), .flags(flags), .bcd_busy(bcd_busy),
        .bcd_valid(bcd_valid), .bcd_digits(bcd_digits)
    );

    // Wide build (12-bit, 8 registers, 4 digits)
    logic        w_reset;
    logic [2:0]  w_reg_sel;
    logic        w_reg_write, w_reg_read, w_alu_latch, w_alu_grab;
    logic [3:0]  w_alu_op;
    logic [11:0] w_bus_in, w_bus_out, w_ir_value;
    logic        w_pc_inc, w_pc_load, w_mar_write, w_ir_write;
    logic [7:0]  w_pc_count, w_mar_value;
    logic [3:0]  w_flags;
    logic        w_bcd_busy, w_bcd_valid;
    logic [15:0] w_bcd_digits;

    param_datapath #(.DATA_W(12), .REG_COUNT(8), .ADDR_W(8), .BCD_DIGITS(4)) dut_w (
        .clock(clock), .reset(w_reset), .reg_sel(w_reg_sel), .reg_write(w_reg_write),
        .reg_read(w_reg_read), .alu_op(w_alu_op), .alu_latch(w_alu_latch), .alu_grab(w_alu_grab),
        .data_bus_in(w_bus_in), .data_bus_out(w_bus_out), .pc_inc(w_pc_inc),
        .pc_load(w_pc_load), .pc_count(w_pc_count), .mar_write(w_mar_write), .ir_write(w_ir_write),
        .mar_value(w_mar_value), .ir_value(w_ir_value), .flags(w_flags), .bcd_busy(w_bcd_busy),
        .bcd_valid(w_bcd_valid), .bcd_digits(w_bcd_digits)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (8-bit build)
    int unsigned m_regs [4];
    int unsigned m_res, m_pc, m_mar, m_ir, m_digits, m_pend;
    logic [3:0]  m_flags;
    int          m_cnt;

    function automatic int unsigned to_bcd(input int unsigned v);
        int unsigned r = 0;
        for (int i = 0; i < 8; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int sgn8(input int unsigned x);
        return (x >= 128) ? int'(x) - 256 : int'(x);
    endfunction

    task automatic ref_alu(input int op, input int unsigned a, input int unsigned b,
                           output int unsigned res, output logic [3:0] f);
        int s = 0;
        int sv = 0;
        logic c = 1'b0;
        case (op)
            0:  begin s = int'(a + b); c = (s > 255); sv = sgn8(a) + sgn8(b); end
            1:  begin s = int'(a) - int'(b); c = (a < b); sv = sgn8(a) - sgn8(b); end
            2:  s = int'(a & b);
            3:  s = int'(a | b);
            4:  s = int'(a ^ b);
            5:  s = 255 - int'(a);
            6:  begin s = int'(a) * 2; c = (a >= 128); end
            7:  begin s = int'(a) / 2; c = (a % 2) == 1; end
            8:  s = int'(b);
            9:  begin s = int'(a) + 1; c = (s > 255); sv = sgn8(a) + 1; end
            10: begin s = int'(a) - 1; c = (a == 0); sv = sgn8(a) - 1; end
            default: s = 0;
        endcase
        res = int'(s) & 255;
        f = {res >= 128, (sv > 127 || sv < -128), c, res == 0};
    endtask

    task automatic model_edge();
        int unsigned nres;
        logic [3:0]  nf;
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_res = 0; m_flags = 0; m_pc = 0; m_mar = 0; m_ir = 0;
            m_cnt = 0; m_digits = 0;
        end else begin
            ref_alu(int'(alu_op), m_regs[reg_sel], data_bus_in, nres, nf);
            if (alu_latch) begin m_res = nres; m_flags = nf; end
            if (reg_write) m_regs[reg_sel] = data_bus_in;
            if (pc_load) m_pc = data_bus_in;
            else if (pc_inc) m_pc = (m_pc + 1) % 256;
            if (mar_write) m_mar = data_bus_in;
            if (ir_write) m_ir = data_bus_in;
            if (alu_latch) begin
                m_cnt = 8; m_pend = nres;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_digits = to_bcd(m_pend);
            end
        end
    endtask

    task automatic tick();
        int unsigned eb;
        @(posedge clock);
        model_edge();
        #1;
        eb = alu_grab ? m_res : (reg_read ? m_regs[reg_sel] : 0);
        check_eq("bus", data_bus_out, eb);
        check_eq("pc", pc_count, m_pc);
        check_eq("mar", mar_value, m_mar);
        check_eq("ir", ir_value, m_ir);
        check_eq("flags", flags, m_flags);
`ifdef DATAPATH_BCD_EN
        check_eq("busy", bcd_busy, m_cnt > 0);
        check_eq("valid", bcd_valid, m_cnt == 0);
        check_eq("digits", bcd_digits, m_digits);
`else
        check_eq("busy", bcd_busy, 1'b0);
        check_eq("valid", bcd_valid, 1'b0);
        check_eq("digits", bcd_digits, 0);
`endif
    endtask

    task automatic idle();
        reset = 0; reg_sel = 0; reg_write = 0; reg_read = 0; alu_op = 0; alu_latch = 0;
        alu_grab = 0; data_bus_in = 0; pc_inc = 0; pc_load = 0; mar_write = 0; ir_write = 0;
    endtask

    initial begin
        idle();
        w_reset = 1; w_reg_sel = 0; w_reg_write = 0; w_reg_read = 0; w_alu_latch = 0;
        w_alu_grab = 0; w_alu_op = 0; w_bus_in = 0; w_pc_inc = 0; w_pc_load = 0;
        w_mar_write = 0; w_ir_write = 0;
        m_cnt = 0; m_pend = 0;

        reset = 1;
        repeat (2) tick();
        idle();
        tick();
        check_eq("rst_bus_idle", data_bus_out, 8'h00);

        // ADD with carry
        reg_sel = 1; reg_write = 1; data_bus_in = 8'hF0; tick();
        idle(); reg_sel = 1; alu_op = 0; data_bus_in = 8'h20; alu_latch = 1; tick();
        idle(); alu_grab = 1; tick();
        check_eq("add_result", data_bus_out, 8'h10);
        check_eq("add_flags", flags, 4'b0010);

        // SUB to zero, then DEC 0xFF and convert
        idle(); reg_sel = 0; reg_write = 1; data_bus_in = 8'h05; tick();
        idle(); alu_op = 1; data_bus_in = 8'h05; alu_latch = 1; tick();
        check_eq("sub_flags", flags, 4'b0001);
        idle(); reg_write = 1; data_bus_in = 8'hFF; tick();
        idle(); alu_op = 10; alu_latch = 1; tick();
        idle();
        repeat (7) tick();
`ifdef DATAPATH_BCD_EN
        check_eq("dec_busy_held", bcd_busy, 1'b1);
`endif
        tick();
`ifdef DATAPATH_BCD_EN
        check_eq("dec_digits", bcd_digits, 12'h254);
        check_eq("dec_valid", bcd_valid, 1'b1);
`endif

        // Abort: 200 then 99 three cycles later
        idle(); alu_op = 8; data_bus_in = 8'd200; alu_latch = 1; tick();
        idle(); repeat (2) tick();
        alu_op = 8; data_bus_in = 8'd99; alu_latch = 1; tick();
        idle(); repeat (8) tick();
`ifdef DATAPATH_BCD_EN
        check_eq("abort_digits", bcd_digits, 12'h099);
`endif

        // PC load / increment wrap / load priority
        idle(); pc_load = 1; data_bus_in = 8'hFE; tick();
        idle(); pc_inc = 1; tick();
        check_eq("pc_ff", pc_count, 8'hFF);
        tick();
        check_eq("pc_wrap", pc_count, 8'h00);
        pc_load = 1; data_bus_in = 8'h10; tick();
        check_eq("pc_load_prio", pc_count, 8'h10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            reg_sel     = 2'($urandom_range(0, 3));
            reg_write   = ($urandom_range(0, 2) == 0);
            reg_read    = $urandom_range(0, 1) == 1;
            alu_op      = 4'($urandom_range(0, 15));
            alu_latch   = ($urandom_range(0, 11) == 0);
            alu_grab    = ($urandom_range(0, 2) == 0);
            data_bus_in = 8'($urandom);
            pc_inc      = $urandom_range(0, 1) == 1;
            pc_load     = ($urandom_range(0, 7) == 0);
            mar_write   = ($urandom_range(0, 3) == 0);
            ir_write    = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        repeat (10) tick();

        // Wide build: 4095 through the 12-bit converter
        @(posedge clock); #1;
        @(posedge clock); #1;
        w_reset = 0; w_reg_sel = 7; w_reg_write = 1; w_bus_in = 12'd4095;
        @(posedge clock); #1;
        w_reg_write = 0; w_reg_read = 1; w_bus_in = 12'd0;
        #1 check_eq("w_reg7", w_bus_out, 12'hFFF);
        w_reg_read = 0; w_alu_op = 8; w_bus_in = 12'd4095; w_alu_latch = 1;
        @(posedge clock); #1;
        w_alu_latch = 0; w_bus_in = 0;
        repeat (11) begin @(posedge clock); #1; end
`ifdef DATAPATH_BCD_EN
        check_eq("w_busy_11", w_bcd_busy, 1'b1);
        check_eq("w_digits_hold", w_bcd_digits, 16'h0000);
`else
        check_eq("w_busy_off", w_bcd_busy, 1'b0);
`endif
        @(posedge clock); #1;
`ifdef DATAPATH_BCD_EN
        check_eq("w_digits", w_bcd_digits, to_bcd(4095));
        check_eq("w_valid", w_bcd_valid, 1'b1);
`else
        check_eq("w_digits_off", w_bcd_digits, 16'h0000);
        check_eq("w_valid_off", w_bcd_valid, 1'b0);
`endif
        w_alu_grab = 1;
        #1 check_eq("w_result", w_bus_out, 12'hFFF);
        check_eq("w_flags", w_flags, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
